// File: rtl/list_pkg.sv
// Shared types and constants for the list_buffer element store.
package list_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_FIFO = 1'b0;
    localparam logic MODE_LIFO = 1'b1;

endpackage

// File: rtl/list_buffer_if.sv
// Producer/consumer bundle for list_buffer: push side, replay stream and status.
interface list_buffer_if #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 256
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             clear;
    logic             push;
    logic [WIDTH-1:0] data_in;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             read_start;
    logic             read_mode;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             read_done;

    modport master (
        output clear, push, data_in, read_start, read_mode, out_ready,
        input  full, empty, count, overflow, busy, out_valid, data_out, read_done
    );

    modport slave (
        input  clear, push, data_in, read_start, read_mode, out_ready,
        output full, empty, count, overflow, busy, out_valid, data_out, read_done
    );
endinterface

// File: rtl/list_mem.sv
// DEPTH x WIDTH register array, one write port and one registered read port.
module list_mem #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage has no reset; only the output register does.
    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/list_buffer.sv
// Element store that collects up to DEPTH words and replays them non-destructively
// in FIFO or LIFO order over a valid/ready stream, ending with a read_done pulse.
module list_buffer #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 256
) (
    input logic         CLK,
    input logic         RST,
    list_buffer_if.slave bus
);
    import list_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          mode_q, mode_d;
    logic          ovf_q, ovf_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;

    logic             mem_we;
    logic             mem_re;
    logic [AW-1:0]    mem_raddr;
    logic [WIDTH-1:0] mem_rdata;
    logic             is_full;
    logic [AW-1:0]    start_idx;
    logic [AW-1:0]    next_idx;

    assign is_full   = (cnt_q == CW'(DEPTH));
    assign start_idx = (bus.read_mode == MODE_LIFO) ? AW'(cnt_q - CW'(1)) : '0;
    // Only evaluated while more than one element remains, so neither direction wraps.
    assign next_idx  = (mode_q == MODE_LIFO) ? idx_q - AW'(1) : idx_q + AW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_raddr = idx_q;

        if (bus.clear) begin
            cnt_d   = '0;
            state_d = IDLE;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.push) begin
                        if (is_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            mem_we = 1'b1;
                            cnt_d  = cnt_q + CW'(1);
                        end
                    end else if (bus.read_start) begin
                        if (cnt_q != '0) begin
                            mode_d    = bus.read_mode;
                            idx_d     = start_idx;
                            rem_d     = cnt_q;
                            valid_d   = 1'b1;
                            mem_re    = 1'b1;
                            mem_raddr = start_idx;
                            state_d   = READ;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                READ: begin
                    if (bus.push) begin
                        ovf_d = 1'b1;
                    end
                    if (valid_q && bus.out_ready) begin
                        if (rem_q == CW'(1)) begin
                            valid_d = 1'b0;
                            state_d = DONE;
                        end else begin
                            idx_d     = next_idx;
                            rem_d     = rem_q - CW'(1);
                            mem_re    = 1'b1;
                            mem_raddr = next_idx;
                        end
                    end
                end
                DONE: begin
                    if (bus.push) begin
                        ovf_d = 1'b1;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            mode_q  <= MODE_FIFO;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    list_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .CLK     (CLK),
        .RST     (RST),
        .we_i    (mem_we),
        .waddr_i (AW'(cnt_q)),
        .wdata_i (bus.data_in),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    assign bus.full      = is_full;
    assign bus.empty     = (cnt_q == '0);
    assign bus.count     = cnt_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = valid_q;
    assign bus.data_out  = mem_rdata;
    assign bus.read_done = done_q;
endmodule

// File: tb/tb_list_buffer.sv
// Directed bench for list_buffer (WIDTH=2, DEPTH=4) with hand-computed expectations.
module tb_list_buffer;
    logic CLK;
    logic RST;
    int   n_cmp;
    int   n_err;

    list_buffer_if #(.WIDTH(2), .DEPTH(4)) bus ();

    list_buffer #(.WIDTH(2), .DEPTH(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [1:0] d);
        bus.push    = 1'b1;
        bus.data_in = d;
        tick;
        bus.push    = 1'b0;
    endtask

    task automatic replay(input string tag, input logic mode,
                          input logic [1:0] e0, input logic [1:0] e1,
                          input logic [1:0] e2, input logic [1:0] e3);
        logic [1:0] exp [4];
        exp = '{e0, e1, e2, e3};
        bus.read_mode  = mode;
        bus.out_ready  = 1'b1;
        bus.read_start = 1'b1;
        tick;
        bus.read_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick;
            check_eq($sformatf("%s_valid%0d", tag, i), bus.out_valid, 1);
            check_eq($sformatf("%s_data%0d", tag, i), bus.data_out, exp[i]);
        end
        tick;
        check_eq({tag, "_end_valid"}, bus.out_valid, 0);
        check_eq({tag, "_end_busy"}, bus.busy, 1);
        check_eq({tag, "_end_done"}, bus.read_done, 0);
        tick;
        check_eq({tag, "_done"}, bus.read_done, 1);
        check_eq({tag, "_done_busy"}, bus.busy, 0);
        tick;
        check_eq({tag, "_done_once"}, bus.read_done, 0);
        check_eq({tag, "_count"}, bus.count, 4);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RST            = 1'b1;
        bus.clear      = 1'b0;
        bus.push       = 1'b0;
        bus.data_in    = '0;
        bus.read_start = 1'b0;
        bus.read_mode  = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (2) tick;
        check_eq("rst_count", bus.count, 0);
        check_eq("rst_empty", bus.empty, 1);
        check_eq("rst_full", bus.full, 0);
        check_eq("rst_ovf", bus.overflow, 0);
        check_eq("rst_valid", bus.out_valid, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.read_done, 0);
        check_eq("rst_data", bus.data_out, 0);
        RST = 1'b0;

        // Fill with 1,2,3,0 and replay in both orders, twice FIFO.
        push_word(2'd1);
        push_word(2'd2);
        push_word(2'd3);
        push_word(2'd0);
        check_eq("fill_count", bus.count, 4);
        check_eq("fill_full", bus.full, 1);
        check_eq("fill_ovf", bus.overflow, 0);
        replay("fifo1", 1'b0, 2'd1, 2'd2, 2'd3, 2'd0);
        replay("lifo1", 1'b1, 2'd0, 2'd3, 2'd2, 2'd1);
        replay("fifo2", 1'b0, 2'd1, 2'd2, 2'd3, 2'd0);

        // LIFO with a 3-cycle stall on the second element and a push during READ.
        bus.read_mode  = 1'b1;
        bus.out_ready  = 1'b1;
        bus.read_start = 1'b1;
        tick;
        bus.read_start = 1'b0;
        check_eq("stall_first", bus.data_out, 0);
        tick;
        check_eq("stall_second", bus.data_out, 3);
        bus.out_ready = 1'b0;
        bus.push      = 1'b1;
        bus.data_in   = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick;
            bus.push = 1'b0;
            check_eq($sformatf("stall_hold_data%0d", i), bus.data_out, 3);
            check_eq($sformatf("stall_hold_valid%0d", i), bus.out_valid, 1);
        end
        check_eq("stall_push_ovf", bus.overflow, 1);
        check_eq("stall_push_count", bus.count, 4);
        bus.out_ready = 1'b1;
        tick;
        check_eq("stall_third", bus.data_out, 2);
        tick;
        check_eq("stall_fourth", bus.data_out, 1);
        tick;
        check_eq("stall_end_valid", bus.out_valid, 0);
        tick;
        check_eq("stall_done", bus.read_done, 1);
        bus.clear = 1'b1;
        tick;
        bus.clear = 1'b0;
        check_eq("clr1_count", bus.count, 0);
        check_eq("clr1_empty", bus.empty, 1);
        check_eq("clr1_ovf", bus.overflow, 0);

        // Five pushes into a depth-4 store: fifth is dropped.
        push_word(2'd1);
        push_word(2'd2);
        push_word(2'd3);
        check_eq("ovf_full_early", bus.full, 0);
        push_word(2'd0);
        check_eq("ovf_full", bus.full, 1);
        check_eq("ovf_not_yet", bus.overflow, 0);
        push_word(2'd2);
        check_eq("ovf_set", bus.overflow, 1);
        check_eq("ovf_count", bus.count, 4);
        replay("ovf_fifo", 1'b0, 2'd1, 2'd2, 2'd3, 2'd0);
        bus.clear = 1'b1;
        tick;
        bus.clear = 1'b0;
        check_eq("clr2_count", bus.count, 0);
        check_eq("clr2_empty", bus.empty, 1);
        check_eq("clr2_ovf", bus.overflow, 0);

        // Replay of an empty store.
        bus.read_mode  = 1'b0;
        bus.read_start = 1'b1;
        tick;
        bus.read_start = 1'b0;
        check_eq("empty_busy", bus.busy, 1);
        check_eq("empty_valid", bus.out_valid, 0);
        check_eq("empty_done_early", bus.read_done, 0);
        tick;
        check_eq("empty_done", bus.read_done, 1);
        check_eq("empty_busy_end", bus.busy, 0);
        check_eq("empty_valid_end", bus.out_valid, 0);
        tick;
        check_eq("empty_done_once", bus.read_done, 0);

        // push and read_start together: push wins, no replay.
        bus.push       = 1'b1;
        bus.data_in    = 2'd2;
        bus.read_start = 1'b1;
        tick;
        bus.push       = 1'b0;
        bus.read_start = 1'b0;
        check_eq("both_count", bus.count, 1);
        check_eq("both_busy", bus.busy, 0);
        tick;
        check_eq("both_valid", bus.out_valid, 0);
        check_eq("both_busy2", bus.busy, 0);

        // RST during a replay, after the second element is presented.
        push_word(2'd1);
        push_word(2'd3);
        push_word(2'd0);
        bus.read_mode  = 1'b0;
        bus.out_ready  = 1'b1;
        bus.read_start = 1'b1;
        tick;
        bus.read_start = 1'b0;
        check_eq("mid_first", bus.data_out, 2);
        tick;
        check_eq("mid_second", bus.data_out, 1);
        #2;
        RST = 1'b1;
        #1;
        check_eq("mid_rst_valid", bus.out_valid, 0);
        check_eq("mid_rst_count", bus.count, 0);
        check_eq("mid_rst_busy", bus.busy, 0);
        check_eq("mid_rst_data", bus.data_out, 0);
        #2;
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check_eq($sformatf("mid_no_done%0d", i), bus.read_done, 0);
        end
        check_eq("mid_count_after", bus.count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
